// File: rtl/lsq_pkg.sv
// lsq_pkg: shared request entry, FSM state and opcode/size constants
// for the LSQ memory access stage.
package lsq_pkg;
   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;
   localparam logic SZ_WORD  = 1'b0;
   localparam logic SZ_BYTE  = 1'b1;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic        is_store;
      logic        size;
      logic [31:0] st_data;
      logic        fwd;
      logic [31:0] fwd_data;
   } mem_req_t;
endpackage

// File: rtl/lsq_req_fifo.sv
// lsq_req_fifo: synchronous FIFO, 2^LOG2 entries of W bits; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module lsq_req_fifo #(
   parameter int LOG2 = 2,
   parameter int W    = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   logic [LOG2:0] wp_q, wp_d, rp_q, rp_d;
   logic [W-1:0]  mem [2**LOG2];

   assign full  = (wp_q[LOG2] != rp_q[LOG2]) && (wp_q[LOG2-1:0] == rp_q[LOG2-1:0]);
   assign empty = wp_q == rp_q;
   assign head  = mem[rp_q[LOG2-1:0]];

   always_comb begin
      wp_d = (push && !full) ? wp_q + 1'b1 : wp_q;
      rp_d = (pop && !empty) ? rp_q + 1'b1 : rp_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wp_q[LOG2-1:0]] <= din;
   end
endmodule

// File: rtl/lsq_mem_stage.sv
// lsq_mem_stage: in-order load/store access to a word RAM with fixed latency;
// forwarded loads bypass the RAM. MEM_BYTE_EN enables byte stores/loads.
module lsq_mem_stage
   import lsq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int MEM_LAT    = 3,
   parameter int FIFO_LOG2  = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_addr,
   input  logic        in_is_store,
   input  logic        in_size,
   input  logic [31:0] in_st_data,
   input  logic        in_fwd,
   input  logic [31:0] in_fwd_data,
   output logic        in_ready,
   output logic        overflow,
   output logic        wb_valid,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_data,
   output logic        wb_is_store,
   output logic        busy
);
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   mem_req_t    work_q, work_d, head, req_in;
   logic        overflow_q, overflow_d, wb_valid_q, wb_valid_d, wb_is_store_q, wb_is_store_d;
   logic [31:0] wb_pc_q, wb_pc_d, wb_data_q, wb_data_d;
   logic        fifo_full, fifo_empty, pop, ram_we, unused_bits;
   logic [31:0] ram [2**DEPTH_LOG2];
   logic [31:0] rd_word, rd_data, wr_word;
   logic [DEPTH_LOG2-1:0] idx;

   assign req_in = '{in_pc, in_addr, in_is_store, in_size, in_st_data, in_fwd, in_fwd_data};

   lsq_req_fifo #(.LOG2(FIFO_LOG2), .W($bits(mem_req_t))) u_fifo (
      .clk(clk), .rstn(rstn), .push(in_valid), .pop(pop), .din(req_in),
      .full(fifo_full), .empty(fifo_empty), .head(head)
   );

   assign idx     = work_q.addr[DEPTH_LOG2+1:2];
   assign rd_word = ram[idx];

`ifdef MEM_BYTE_EN
   logic [1:0] lane;
   logic [7:0] rd_byte;
   assign lane        = work_q.addr[1:0];
   assign rd_byte     = rd_word[{lane, 3'b000} +: 8];
   assign rd_data     = (work_q.size == SZ_BYTE) ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
   assign unused_bits = ^work_q.addr[31:DEPTH_LOG2+2];
   always_comb begin
      wr_word = work_q.st_data;
      if (work_q.size == SZ_BYTE) begin
         wr_word = rd_word;
         wr_word[{lane, 3'b000} +: 8] = work_q.st_data[7:0];
      end
   end
`else
   assign rd_data     = rd_word;
   assign wr_word     = work_q.st_data;
   assign unused_bits = ^{work_q.addr[31:DEPTH_LOG2+2], work_q.addr[1:0], work_q.size};
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      work_d        = work_q;
      pop           = 1'b0;
      ram_we        = 1'b0;
      wb_valid_d    = 1'b0;
      wb_pc_d       = wb_pc_q;
      wb_data_d     = wb_data_q;
      wb_is_store_d = wb_is_store_q;
      overflow_d    = overflow_q | (in_valid & fifo_full);
      if (state_q == ST_IDLE && !fifo_empty) begin
         pop = 1'b1;
         if (head.fwd) begin
            wb_valid_d    = 1'b1;
            wb_pc_d       = head.pc;
            wb_data_d     = head.fwd_data;
            wb_is_store_d = head.is_store;
         end else begin
            work_d  = head;
            cnt_d   = 4'(MEM_LAT - 1);
            state_d = ST_ACCESS;
         end
      end else if (state_q == ST_ACCESS) begin
         cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
         if (cnt_q == 4'd0) begin
            ram_we        = work_q.is_store == OP_STORE;
            wb_valid_d    = 1'b1;
            wb_pc_d       = work_q.pc;
            wb_data_d     = (work_q.is_store == OP_STORE) ? 32'd0 : rd_data;
            wb_is_store_d = work_q.is_store;
            state_d       = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         work_q        <= '0;
         overflow_q    <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_pc_q       <= '0;
         wb_data_q     <= '0;
         wb_is_store_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         work_q        <= work_d;
         overflow_q    <= overflow_d;
         wb_valid_q    <= wb_valid_d;
         wb_pc_q       <= wb_pc_d;
         wb_data_q     <= wb_data_d;
         wb_is_store_q <= wb_is_store_d;
      end
   end

   // write enable derives from reset-cleared state, so reset aborts a pending store
   always_ff @(posedge clk) begin
      if (ram_we) ram[idx] <= wr_word;
   end

   assign in_ready    = !fifo_full;
   assign overflow    = overflow_q;
   assign wb_valid    = wb_valid_q;
   assign wb_pc       = wb_pc_q;
   assign wb_data     = wb_data_q;
   assign wb_is_store = wb_is_store_q;
   assign busy        = !fifo_empty || state_q != ST_IDLE;
endmodule

// File: tb/tb_lsq_mem_stage.sv
// tb_lsq_mem_stage: random and directed requests checked by a scoreboard fed
// from a behavioural memory/timing model.
module tb_lsq_mem_stage;
   localparam int LAT = 3;
   localparam int NWORDS = 1024;
   localparam int FIFO_N = 4;

   logic clk = 0, rstn = 0;
   logic in_valid = 0, in_is_store = 0, in_size = 0, in_fwd = 0;
   logic [31:0] in_pc = 0, in_addr = 0, in_st_data = 0, in_fwd_data = 0;
   logic in_ready, overflow, wb_valid, wb_is_store, busy;
   logic [31:0] wb_pc, wb_data;

   lsq_mem_stage #(.DEPTH_LOG2(10), .MEM_LAT(LAT), .FIFO_LOG2(2)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pc(in_pc), .in_addr(in_addr),
      .in_is_store(in_is_store), .in_size(in_size), .in_st_data(in_st_data),
      .in_fwd(in_fwd), .in_fwd_data(in_fwd_data), .in_ready(in_ready),
      .overflow(overflow), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data),
      .wb_is_store(wb_is_store), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        st;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          pops[$];
   logic [31:0] mm [NWORDS];
   int          cyc = 0, free_e = 0, n_cmp = 0, n_bad = 0;
   logic        ovf_m = 0;
   logic [31:0] pc_n = 32'h1000;
   exp_t        mon_e;

   always @(posedge clk) cyc++;

   function void chk(string name, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endfunction

   always @(negedge clk) begin
      if (rstn && wb_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected: got pc %h expected no completion", wb_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_pc", wb_pc, mon_e.pc);
            chk("wb_data", wb_data, mon_e.data);
            chk("wb_is_store", {31'd0, wb_is_store}, {31'd0, mon_e.st});
            chk("wb_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic issue(input logic v, input logic st, input logic sz, input logic [31:0] addr,
                        input logic [31:0] sd, input logic fwd, input logic [31:0] fd);
      int e, p, done, idx, lane;
      logic rdy;
      logic [31:0] w, d;
      logic [7:0] b;
      @(negedge clk);
      in_valid = v; in_pc = pc_n; in_addr = addr; in_is_store = st; in_size = sz;
      in_st_data = sd; in_fwd = fwd; in_fwd_data = fd;
      e = cyc + 1;
      while (pops.size() > 0 && pops[0] < e) void'(pops.pop_front());
      rdy = pops.size() < FIFO_N;
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      if (v && !rdy) ovf_m = 1;
      if (v && rdy) begin
         p = (e + 1 > free_e) ? e + 1 : free_e;
         done = fwd ? p : p + LAT;
         free_e = done + 1;
         pops.push_back(p);
         idx = int'((addr >> 2) % NWORDS);
         lane = int'(addr % 4);
         w = mm[idx];
         d = w;
`ifdef MEM_BYTE_EN
         if (sz) begin
            b = 8'(w >> (8 * lane));
            d = {{24{b[7]}}, b};
            if (st) mm[idx] = (w & ~(32'hFF << (8 * lane))) | ({24'd0, sd[7:0]} << (8 * lane));
         end else if (st) mm[idx] = sd;
`else
         b = 8'(lane);
         if (st) mm[idx] = sd;
`endif
         if (fwd) d = fd;
         if (st) d = 0;
         exp_q.push_back('{pc_n, d, st, done});
      end
      pc_n += 4;
      @(posedge clk);
      #1;
      in_valid = 0;
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic check_idle_outputs(string tag);
      chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 0);
      chk({tag, "_wb_pc"}, wb_pc, 0);
      chk({tag, "_wb_data"}, wb_data, 0);
      chk({tag, "_wb_is_store"}, {31'd0, wb_is_store}, 0);
      chk({tag, "_overflow"}, {31'd0, overflow}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] saved;
      int idx;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rstn = 1;
      // store then dependent load
      issue(1, 1, 0, 32'h40, 32'hDEADBEEF, 0, 0);
      issue(1, 0, 0, 32'h40, 0, 0, 0);
      drain();
      // forwarded load into an idle block
      issue(1, 0, 0, 32'h40, 0, 1, 32'h1234);
      drain();
`ifdef MEM_BYTE_EN
      issue(1, 1, 0, 32'h80, 32'h11223344, 0, 0);
      issue(1, 1, 1, 32'h81, 32'h000000F0, 0, 0);
      issue(1, 0, 1, 32'h81, 0, 0, 0);
      issue(1, 0, 0, 32'h80, 0, 0, 0);
      drain();
`endif
      // address wraps modulo RAM size
      issue(1, 1, 0, 32'h1000, 32'hA5A5A5A5, 0, 0);
      issue(1, 0, 0, 32'h0, 0, 0, 0);
      drain();
      // fill the FIFO while the head op is in ACCESS
      issue(1, 1, 0, 32'h44, 32'h5555AAAA, 0, 0);
      issue(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) issue(1, 0, 0, 32'h44, 0, 0, 0);
      drain();
      // randomized traffic over 16 words with random upper/lower address bits
      for (int i = 0; i < 16; i++)
         issue(1, 1, 0, ($urandom() & 32'hFFFF_F003) | (i << 2), $urandom(), 0, 0);
      for (int i = 0; i < 300; i++) begin
         logic v, st, fw;
         v = $urandom_range(0, 9) < 6;
         st = $urandom_range(0, 2) == 0;
         fw = !st && $urandom_range(0, 2) == 0;
         issue(v, st, 1'($urandom_range(0, 1)), ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
               $urandom(), fw, $urandom());
      end
      drain();
      // reset during a store's ACCESS aborts the write
      issue(1, 1, 0, 32'h20, 32'h11, 0, 0);
      drain();
      idx = 8;
      saved = mm[idx];
      issue(1, 1, 0, 32'h20, 32'h77, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("busy_access", {31'd0, busy}, 1);
      rstn = 0;
      #1;
      check_idle_outputs("midreset");
      exp_q.delete();
      pops.delete();
      free_e = 0;
      ovf_m = 0;
      mm[idx] = saved;
      @(negedge clk);
      rstn = 1;
      issue(1, 0, 0, 32'h20, 0, 0, 0);
      drain();
      chk("final_busy", {31'd0, busy}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
